// File: rtl/etomux_pkg.sv
// Shared sizing constants and the select decode helper for the etomux block.
package etomux_pkg;

  localparam int N_CH      = 8;
  localparam int SEL_W     = 3;
  localparam int CNT_W_DEF = 8;

  // Shifting a single one into place keeps X/Z on the select visible as X in simulation.
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
    return {{(N_CH-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/etomux_core.sv
// Combinational 8:1 mux and one-hot select decoder with no clocked state.
module etomux_core
  import etomux_pkg::*;
(
  input  logic [N_CH-1:0]  a,
  input  logic [SEL_W-1:0] s,
  output logic             q,
  output logic [N_CH-1:0]  sel_oh
);

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    q      = a[s];
    sel_oh = onehot(s);
  end

endmodule

// File: rtl/etomux.sv
// Mux top: combinational select path plus registered output, edge pulses and a saturating high-cycle counter.
module etomux
  import etomux_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [N_CH-1:0]  a,
  input  logic [SEL_W-1:0] s,
  output logic             q,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [N_CH-1:0]  sel_oh,
  output logic             q_r,
  output logic             q_rise,
  output logic             q_fall,
  output logic [CNT_W-1:0] hi_cnt
);

  logic q_r_d;

  etomux_core u_core (
    .a      (a),
    .s      (s),
    .q      (q),
    .sel_oh (sel_oh)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= 1'b0;
      q_r_d <= 1'b0;
    end else begin
      if (en) q_r <= q;
      // The delayed copy follows every cycle, so a held q_r stops pulsing after one cycle.
      q_r_d <= q_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hi_cnt <= '0;
    else if (q_r && (hi_cnt != {CNT_W{1'b1}}))
      hi_cnt <= hi_cnt + CNT_W'(1);
  end

  // Both pulses are zero while in reset because q_r and q_r_d are both cleared.
  assign q_rise = q_r & ~q_r_d;
  assign q_fall = ~q_r & q_r_d;

endmodule

// File: tb/tb_etomux.sv
// Self-checking bench for etomux: vector table for the mux/decoder, directed sequences for the registered path.
module tb_etomux;
  import etomux_pkg::*;

  logic [N_CH-1:0]  a;
  logic [SEL_W-1:0] s;
  logic             clk;
  logic             rst_n;
  logic             en;

  logic             q,  q_r,  q_rise,  q_fall;
  logic [N_CH-1:0]  sel_oh;
  logic [7:0]       hi_cnt;

  logic             q2, q_r2, q_rise2, q_fall2;
  logic [N_CH-1:0]  sel_oh2;
  logic [1:0]       hi_cnt2;

  int checks = 0;
  int errors = 0;

  etomux dut (
    .a(a), .s(s), .q(q), .clk(clk), .rst_n(rst_n), .en(en),
    .sel_oh(sel_oh), .q_r(q_r), .q_rise(q_rise), .q_fall(q_fall), .hi_cnt(hi_cnt)
  );

  etomux #(.CNT_W(2)) dut2 (
    .a(a), .s(s), .q(q2), .clk(clk), .rst_n(rst_n), .en(en),
    .sel_oh(sel_oh2), .q_r(q_r2), .q_rise(q_rise2), .q_fall(q_fall2), .hi_cnt(hi_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic       q;
    logic [7:0] oh;
  } vec_t;

  vec_t vecs[12];
  logic [1:0] cnt_exp[6];

  initial begin
    vecs[0]  = '{8'b01101111, 3'd0, 1'b1, 8'h01};
    vecs[1]  = '{8'b01101111, 3'd1, 1'b1, 8'h02};
    vecs[2]  = '{8'b01101111, 3'd2, 1'b1, 8'h04};
    vecs[3]  = '{8'b01101111, 3'd3, 1'b1, 8'h08};
    vecs[4]  = '{8'b01101111, 3'd4, 1'b0, 8'h10};
    vecs[5]  = '{8'b01101111, 3'd5, 1'b1, 8'h20};
    vecs[6]  = '{8'b01101111, 3'd6, 1'b1, 8'h40};
    vecs[7]  = '{8'b01101111, 3'd7, 1'b0, 8'h80};
    vecs[8]  = '{8'hA5,       3'd2, 1'b1, 8'h04};
    vecs[9]  = '{8'hA5,       3'd6, 1'b0, 8'h40};
    vecs[10] = '{8'h00,       3'd7, 1'b0, 8'h80};
    vecs[11] = '{8'hFF,       3'd5, 1'b1, 8'h20};
    cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    a = 8'b01101111; s = 3'd0; en = 1'b0; rst_n = 1'b0;
    #12;
    check("reset q_r",    32'(q_r),    32'd0);
    check("reset q_rise", 32'(q_rise), 32'd0);
    check("reset q_fall", 32'(q_fall), 32'd0);
    check("reset hi_cnt", 32'(hi_cnt), 32'd0);

    // Mux and decoder are combinational and live even under reset.
    for (int i = 0; i < 12; i++) begin
      a = vecs[i].a;
      s = vecs[i].s;
      #10;
      check($sformatf("q vec%0d", i),      32'(q),      32'(vecs[i].q));
      check($sformatf("sel_oh vec%0d", i), 32'(sel_oh), 32'(vecs[i].oh));
    end

    // Edge pulses from the registered path.
    rst_n = 1'b1;
    a = 8'b01101111; s = 3'd3; en = 1'b1;
    step();
    check("seq q_r after s=3",  32'(q_r),    32'd1);
    check("seq rise after s=3", 32'(q_rise), 32'd1);
    check("seq fall after s=3", 32'(q_fall), 32'd0);
    s = 3'd4;
    step();
    check("seq q_r after s=4",  32'(q_r),    32'd0);
    check("seq fall after s=4", 32'(q_fall), 32'd1);
    check("seq rise after s=4", 32'(q_rise), 32'd0);
    step();
    check("seq fall one cycle", 32'(q_fall), 32'd0);
    s = 3'd3;
    step();
    check("seq rise back s=3",  32'(q_rise), 32'd1);
    step();
    check("seq rise one cycle", 32'(q_rise), 32'd0);
    check("seq q_r steady",     32'(q_r),    32'd1);

    // Hold with en low while q changes.
    en = 1'b0; s = 3'd4;
    #1;
    check("hold q combinational", 32'(q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold q_r c%0d", i),  32'(q_r),    32'd1);
      check($sformatf("hold rise c%0d", i), 32'(q_rise), 32'd0);
      check($sformatf("hold fall c%0d", i), 32'(q_fall), 32'd0);
    end

    // Saturating counter on the 2-bit instance.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    a = 8'hFF; s = 3'd0; en = 1'b1;
    step();
    check("cnt q_r loaded", 32'(q_r2),   32'd1);
    check("cnt start",      32'(hi_cnt2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("cnt cycle%0d", i), 32'(hi_cnt2), 32'(cnt_exp[i]));
    end
    check("cnt 8bit unsaturated", 32'(hi_cnt), 32'd6);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst hi_cnt", 32'(hi_cnt2), 32'd0);
    check("async rst q_r",    32'(q_r2),    32'd0);
    check("async rst q live", 32'(q2),      32'd1);
    a = 8'b01101111; s = 3'd4;
    #1;
    check("rst q tracks",      32'(q),      32'd0);
    check("rst sel_oh tracks", 32'(sel_oh), 32'h10);
    rst_n = 1'b1;
    step();
    check("post rst q_r",     32'(q_r),    32'd0);
    check("post rst no fall", 32'(q_fall), 32'd0);
    check("post rst no rise", 32'(q_rise), 32'd0);
    s = 3'd3;
    step();
    check("post rst rise",    32'(q_rise), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
